// File: rtl/morse_sym_timer.sv
// morse_sym_timer
// ---------------
// Times one Morse dot or dash per request and drives the LED for it. Each
// symbol is followed by a mandatory LED-off gap and then a one-cycle
// completion pulse. A new request can be accepted in the completion cycle,
// so symbols can run back to back with no idle cycle between them.
//
// Optional build macro: MORSE_ABORT_EN adds the sym_abort input. An abort
// raised in ON or GAP cuts the symbol short. The LED goes dark on the next
// cycle, and sym_done pulses one cycle after that.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   sym_strt  in   symbol request, sampled only in IDLE/DONE
//   symbol    in   1 = dash, 0 = dot, sampled with sym_strt
//   sym_abort in   (MORSE_ABORT_EN only) synchronous abort, active high
//   sym_busy  out  high while a symbol or its gap is in progress
//   led_drv   out  LED drive, active high
//   sym_done  out  one-cycle completion pulse
module morse_sym_timer #(
    parameter int UNIT_CYCLES = 4,
    parameter int DOT_UNITS   = 1,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 1,
    parameter int CNT_W       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sym_strt,
    input  logic symbol,
`ifdef MORSE_ABORT_EN
    input  logic sym_abort,
`endif
    output logic sym_busy,
    output logic led_drv,
    output logic sym_done
);

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, busy_q, done_q;
    logic             abort;

`ifdef MORSE_ABORT_EN
    assign abort = sym_abort;
`else
    assign abort = 1'b0;
`endif

    // The symbol is latched by loading its duration into the counter at
    // accept time. Later changes on 'symbol' cannot alter the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (sym_strt) begin
                    state_d = ON;
                    cnt_d   = symbol ? DASH_LD : DOT_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            ON: begin
                // An abort parks in GAP with an empty count. This gives one
                // dark, busy cycle before DONE.
                if (abort) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                // Normal completion on the last gap cycle takes priority
                // over an abort, so it never adds an extra cycle.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (abort) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The outputs are registered from the next state. Each output therefore
    // lines up with the state that the flops hold during the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= (state_d == ON);
            busy_q  <= (state_d == ON) || (state_d == GAP);
            done_q  <= (state_d == DONE);
        end
    end

    assign led_drv  = led_q;
    assign sym_busy = busy_q;
    assign sym_done = done_q;

endmodule

// File: tb/tb_morse_sym_timer.sv
// Bench for morse_sym_timer. It runs two instances side by side on the same
// stimulus: the defaults (A) and UNIT_CYCLES=1, DASH_UNITS=5, GAP_UNITS=2 (B).
// Each instance has a reference model. The model tracks the position inside
// the current symbol as a cycle index and derives the expected outputs from
// the unit arithmetic.
module tb_morse_sym_timer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sym_strt = 1'b0;
    logic symbol = 1'b0;
`ifdef MORSE_ABORT_EN
    logic sym_abort = 1'b0;
`endif
    logic la, ba, da, lb, bb, db;

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    // model parameters per instance: [0]=A, [1]=B
    int pu[2] = '{4, 1};
    int pdot[2] = '{1, 1};
    int pdash[2] = '{3, 5};
    int pgap[2] = '{1, 2};
    // rel: 0 = idle, 1..onl = LED on, ..tot = gap, tot+1 = done cycle
    int rel[2] = '{0, 0};
    int onl[2] = '{0, 0};
    int tot[2] = '{0, 0};

    always #5 clock = ~clock;

    morse_sym_timer u_a (
        .clock(clock), .reset(reset), .sym_strt(sym_strt), .symbol(symbol),
`ifdef MORSE_ABORT_EN
        .sym_abort(sym_abort),
`endif
        .sym_busy(ba), .led_drv(la), .sym_done(da));

    morse_sym_timer #(.UNIT_CYCLES(1), .DOT_UNITS(1), .DASH_UNITS(5),
                      .GAP_UNITS(2), .CNT_W(8)) u_b (
        .clock(clock), .reset(reset), .sym_strt(sym_strt), .symbol(symbol),
`ifdef MORSE_ABORT_EN
        .sym_abort(sym_abort),
`endif
        .sym_busy(bb), .led_drv(lb), .sym_done(db));

    function automatic logic [2:0] obs(input int d);
        return (d == 0) ? {la, ba, da} : {lb, bb, db};
    endfunction

    // expected {led, busy, done}
    function automatic logic [2:0] ex(input int d);
        int r;
        r = rel[d];
        return {r >= 1 && r <= onl[d], r >= 1 && r <= tot[d], r == tot[d] + 1};
    endfunction

    // Drive one cycle of inputs, advance the models over the edge and return
    // at the following falling edge, where outputs are stable.
    task automatic tick(input bit s, input bit sy, input bit ab);
        bit abe;
        sym_strt = s;
        symbol   = sy;
`ifdef MORSE_ABORT_EN
        sym_abort = ab;
        abe = ab;
`else
        abe = 1'b0;
`endif
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            if (rel[d] == 0 || rel[d] == tot[d] + 1) begin
                if (s) begin
                    onl[d] = (sy ? pdash[d] : pdot[d]) * pu[d];
                    tot[d] = onl[d] + pgap[d] * pu[d];
                    rel[d] = 1;
                end else begin
                    rel[d] = 0;
                end
            end else if (abe && rel[d] < tot[d]) begin
                rel[d] = tot[d];
            end else begin
                rel[d] = rel[d] + 1;
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset;
        #1;
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if ({la, ba, da, lb, bb, db} !== 6'b0) begin
                miss++;
                $display("FAIL reset outs got %b want 000000", {la, ba, da, lb, bb, db});
            end
            @(negedge clock);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            for (int d = 0; d < 2; d++) begin
                vecs++;
                if (obs(d) !== ex(d)) begin
                    miss++;
                    $display("FAIL idle dut%0d got %b want %b", d, obs(d), ex(d));
                end
            end
        end
    endtask

    // Runs one symbol starting at edge 0 and records the first done cycle
    // of each instance.
    task automatic run_sym(input string nm, input bit sy, input int wa, input int wb);
        int fa, fb;
        fa = -1;
        fb = -1;
        cyc = 0;
        tick(1, sy, 0);
        for (int i = 0; i < 24; i++) begin
            for (int d = 0; d < 2; d++) begin
                vecs++;
                if (obs(d) !== ex(d)) begin
                    miss++;
                    $display("FAIL %s dut%0d cyc%0d got %b want %b", nm, d, cyc, obs(d), ex(d));
                end
            end
            if (da && fa < 0) fa = cyc;
            if (db && fb < 0) fb = cyc;
            tick(0, 0, 0);
        end
        vecs++;
        if (fa != wa || fb != wb) begin
            miss++;
            $display("FAIL %s done_cycle got %0d/%0d want %0d/%0d", nm, fa, fb, wa, wb);
        end
    endtask

    task automatic test_dot;
        run_sym("dot", 1'b0, 9, 4);
    endtask

    task automatic test_dash;
        run_sym("dash", 1'b1, 17, 8);
    endtask

    task automatic test_back_to_back;
        int n;
        int second;
        n = 0;
        second = -1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0);
            for (int d = 0; d < 2; d++) begin
                vecs++;
                if (obs(d) !== ex(d)) begin
                    miss++;
                    $display("FAIL b2b dut%0d cyc%0d got %b want %b", d, cyc, obs(d), ex(d));
                end
            end
            if (da) begin
                n++;
                if (n == 2) second = cyc;
            end
        end
        vecs++;
        if (second != 18) begin
            miss++;
            $display("FAIL b2b second_done got %0d want 18", second);
        end
        for (int i = 0; i < 20; i++) tick(0, 0, 0);
    endtask

    task automatic test_ignore_busy;
        int n;
        int fa;
        n = 0;
        fa = -1;
        cyc = 0;
        tick(1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 2; d++) begin
                vecs++;
                if (obs(d) !== ex(d)) begin
                    miss++;
                    $display("FAIL ignore dut%0d cyc%0d got %b want %b", d, cyc, obs(d), ex(d));
                end
            end
            if (da) begin
                n++;
                if (fa < 0) fa = cyc;
            end
            tick(cyc == 3, cyc[0], 0);
        end
        vecs++;
        if (n != 1 || fa != 9) begin
            miss++;
            $display("FAIL ignore dones got %0d@%0d want 1@9", n, fa);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        nd = 0;
        cyc = 0;
        tick(1, 1, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        reset = 1'b0;
        rel[0] = 0;
        rel[1] = 0;
        #1;
        vecs++;
        if ({la, ba, da, lb, bb, db} !== 6'b0) begin
            miss++;
            $display("FAIL rst_mid outs got %b want 000000", {la, ba, da, lb, bb, db});
        end
        #2;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            if (da || db) nd++;
        end
        vecs++;
        if (nd != 0) begin
            miss++;
            $display("FAIL rst_mid spurious_done got %0d want 0", nd);
        end
        run_sym("dot_after_rst", 1'b0, 9, 4);
    endtask

`ifdef MORSE_ABORT_EN
    task automatic test_abort;
        cyc = 0;
        tick(1, 1, 0);
        tick(0, 0, 0);
        tick(0, 0, 1);
        vecs++;
        if ({lb, bb, db} !== 3'b010 || obs(0) !== ex(0)) begin
            miss++;
            $display("FAIL abort cyc3 got %b/%b want 010/%b", {lb, bb, db}, obs(0), ex(0));
        end
        tick(0, 0, 0);
        vecs++;
        if ({lb, bb, db} !== 3'b001 || obs(0) !== ex(0)) begin
            miss++;
            $display("FAIL abort cyc4 got %b/%b want 001/%b", {lb, bb, db}, obs(0), ex(0));
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
    endtask
`endif

    task automatic test_random;
        bit s, sy, ab;
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 3) == 0);
            sy = $urandom_range(0, 1) == 1;
            ab = ($urandom_range(0, 15) == 0);
            tick(s, sy, ab);
            for (int d = 0; d < 2; d++) begin
                vecs++;
                if (obs(d) !== ex(d)) begin
                    miss++;
                    $display("FAIL random dut%0d step%0d got %b want %b", d, i, obs(d), ex(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_dash();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
`ifdef MORSE_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/morse_sym_timer.md
Name: morse_sym_timer

Overview:
Parametrised Morse symbol timer; next-generation LED driver stage of the Morse encoder.
Times one dot or dash per request, then a mandatory inter-symbol gap, then reports completion.
Unit length, dot, dash and gap durations are set by parameters.
Sits between the character sequencer (issues sym_strt/symbol) and the LED pin.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit; must be >= 1
DOT_UNITS, 1, LED-on units for a dot; must be >= 1
DASH_UNITS, 3, LED-on units for a dash; must be >= 1
GAP_UNITS, 1, LED-off units after every symbol; must be >= 1
CNT_W, 16, width of the duration counter; must hold max(DASH_UNITS, DOT_UNITS, GAP_UNITS)*UNIT_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
sym_strt  in  1  symbol request; sampled only when accepted (see Behaviour)
symbol  in  1  1 = dash, 0 = dot; sampled with sym_strt
sym_busy  out  1  high while a symbol or its gap is in progress
led_drv  out  1  LED drive, active high
sym_done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. While reset is low: state IDLE, counter 0, led_drv=0, sym_busy=0, sym_done=0.
- States: IDLE, ON, GAP, DONE.
- IDLE:
  - If sym_strt=1, latch symbol and load the counter with (symbol ? DASH_UNITS : DOT_UNITS)*UNIT_CYCLES-1.
  - Move to ON; led_drv=1 and sym_busy=1 from the next cycle.
  - Otherwise stay in IDLE.
- ON:
  - Counter decrements once per cycle.
  - At counter=0, load GAP_UNITS*UNIT_CYCLES-1 and move to GAP. led_drv drops the next cycle.
  - Dot on-time is exactly DOT_UNITS*UNIT_CYCLES cycles; dash on-time is DASH_UNITS*UNIT_CYCLES cycles.
- GAP:
  - led_drv=0, sym_busy=1, counter decrements.
  - At counter=0, move to DONE.
- DONE:
  - Lasts one cycle: sym_done=1, sym_busy=0, led_drv=0.
  - sym_strt=1 in DONE is accepted exactly as in IDLE (back-to-back symbols, no dead cycle). Otherwise go to IDLE.
- sym_strt and symbol are ignored in ON and GAP. No queuing; the requester must wait for sym_done or sym_busy=0.
- The latched symbol is held for the whole symbol; symbol changes after acceptance have no effect.
- Reset asserted mid-symbol:
  - Immediately forces IDLE and all outputs 0.
  - No sym_done is produced for the aborted symbol.
- Latency from accept edge to led_drv=1 is 1 cycle. Total request-to-sym_done time is (on_units+GAP_UNITS)*UNIT_CYCLES+1 cycles.
- Default-case recovery: any illegal state encoding goes to IDLE with outputs 0.

Optional Feature:
MORSE_ABORT_EN
- Defined:
  - Adds input port sym_abort (1 bit, active high, synchronous).
  - sym_abort=1 in ON or GAP forces led_drv=0 next cycle and moves to DONE, so sym_done pulses one cycle later.
  - In IDLE or DONE, sym_abort is ignored. If sym_abort=1 and sym_strt=1 arrive in the same cycle in IDLE, the start wins.
- Undefined: no sym_abort port; behaviour exactly as above.

Test Plan:
1. Defaults, dot. sym_strt=1, symbol=0 at edge 0 -> led_drv=1 in cycles 1-4; led_drv=0 and sym_busy=1 in cycles 5-8; sym_done=1 only in cycle 9; IDLE in cycle 10.
2. Defaults, dash. sym_strt=1, symbol=1 at edge 0 -> led_drv=1 in cycles 1-12; gap in cycles 13-16; sym_done in cycle 17.
3. Back-to-back. Hold sym_strt=1 with symbol=0 -> second LED-on starts in the cycle after sym_done; no IDLE cycle between symbols; second sym_done at cycle 18.
4. Ignore while busy. Pulse sym_strt=1, symbol=1 at cycle 3 of a dot; toggle symbol during ON -> timing is identical to test 1; exactly one sym_done.
5. Reset mid-dash. Drive reset low at cycle 6 -> led_drv, sym_busy and sym_done go 0 asynchronously; after release, no sym_done; a new dot times correctly.
6. Parameters UNIT_CYCLES=1, DASH_UNITS=5, GAP_UNITS=2 with a dash -> led_drv high for 5 cycles, then 2 gap cycles, then a 1-cycle sym_done. With MORSE_ABORT_EN, sym_abort at cycle 2 -> led_drv=0 at cycle 3, sym_done at cycle 4.
